ram_write_ctrl: RTL and testbench

RAM_WRITE_CTRL -- requirements
Module: ram_write_ctrl

---
 rtl/ram_dp_pkg.sv | 15 +
 rtl/ram_dual_port.sv | 32 +++
 rtl/ram_write_ctrl.sv | 136 +++++++++++++
 tb/tb_ram_write_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_dp_pkg.sv
// Shared constants and state type for the dual-port RAM write path.
// Used by ram_write_ctrl, ram_dual_port and the bench.
package ram_dp_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wr_state_e;

endpackage

// File: rtl/ram_dual_port.sv
// Simple dual-clock RAM: synchronous write on write_clk and a registered
// read on read_clk. This is the target that ram_write_ctrl drives.
module ram_dual_port #(
    parameter int ADDR_W = ram_dp_pkg::ADDR_W,
    parameter int DATA_W = ram_dp_pkg::DATA_W,
    parameter int DEPTH  = ram_dp_pkg::DEPTH
) (
    input  logic              write_clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read_clk,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [DATA_W-1:0] read_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: store one word per we pulse.
    // NOTE: the storage array has no reset so it maps onto block RAM.
    always_ff @(posedge write_clk) begin
        if (we) begin
            mem[write_addr] <= write_data;
        end
    end

    // Read port: one-cycle registered read in the read_clk domain.
    always_ff @(posedge read_clk) begin
        read_data <= mem[read_addr];
    end

endmodule

// File: rtl/ram_write_ctrl.sv
// Frame write controller: accepts a start request with a base address and a
// beat count, then turns an upstream valid/ready byte stream into RAM write
// pulses at consecutive (wrapping) addresses.
// Optional feature: define RAM_WR_CHKSUM_EN to build the running frame
// checksum; without it the chksum port is tied to zero.
module ram_write_ctrl #(
    parameter int ADDR_W = ram_dp_pkg::ADDR_W,
    parameter int DATA_W = ram_dp_pkg::DATA_W,
    parameter int DEPTH  = ram_dp_pkg::DEPTH
) (
    input  logic              write_clk,
    input  logic              write_rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic              err_len,
    output logic [ADDR_W:0]   wr_count,
    output logic [DATA_W-1:0] chksum
);

    import ram_dp_pkg::*;

    localparam int                LEN_W    = ADDR_W + 1;
    localparam logic [ADDR_W:0]   LEN_MAX  = LEN_W'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    wr_state_e         state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   len_q;

    logic              accept;
    logic              len_ok;
    logic              frame_go;
    logic [ADDR_W:0]   count_next;

    // in_ready is only ever high in WRITE, so it alone qualifies a beat.
    assign accept     = in_valid && in_ready;
    assign len_ok     = (len != '0) && (len <= LEN_MAX);
    assign frame_go   = (state == IDLE) && start && len_ok;
    assign count_next = wr_count + CNT_ONE;

    // Frame FSM with all outputs registered alongside the state.
    // NOTE: every state element uses <= so all updates see pre-edge values.
    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            we         <= 1'b0;
            write_addr <= '0;
            data       <= '0;
            done       <= 1'b0;
            err_len    <= 1'b0;
            wr_count   <= '0;
        end else begin
            we      <= 1'b0;
            done    <= 1'b0;
            err_len <= 1'b0;

            // Beat path: one write pulse per accepted beat, one cycle later.
            if (accept) begin
                we         <= 1'b1;
                write_addr <= addr_q;
                data       <= in_data;
                addr_q     <= addr_q + ADDR_ONE;
                wr_count   <= count_next;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            addr_q   <= base_addr;
                            len_q    <= len;
                            wr_count <= '0;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                            state    <= WRITE;
                        end else begin
                            err_len <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    // Abort wins over completion: no done for an aborted frame.
                    if (abort) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else if (accept && (count_next == len_q)) begin
                        in_ready <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef RAM_WR_CHKSUM_EN
    // Running mod-2**DATA_W sum of the beats accepted in the current frame.
    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            chksum <= '0;
        end else if (frame_go) begin
            chksum <= '0;
        end else if (accept) begin
            chksum <= chksum + in_data;
        end
    end
`else
    assign chksum = '0;
`endif

endmodule

// File: tb/tb_ram_write_ctrl.sv
// Self-checking bench for ram_write_ctrl feeding a ram_dual_port.
// Expected writes, counts and checksums come from a frame-level model.
`timescale 1ns/1ps
module tb_ram_write_ctrl;

    import ram_dp_pkg::*;

`ifdef RAM_WR_CHKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic              write_clk = 1'b0;
    logic              read_clk  = 1'b0;
    logic              write_rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   len = '0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              we;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic              done;
    logic              err_len;
    logic [ADDR_W:0]   wr_count;
    logic [DATA_W-1:0] chksum;
    logic [ADDR_W-1:0] read_addr = '0;
    logic [DATA_W-1:0] read_data;

    always #5 write_clk = ~write_clk;
    always #7 read_clk  = ~read_clk;

    ram_write_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .write_clk  (write_clk),
        .write_rst_n(write_rst_n),
        .start      (start),
        .abort      (abort),
        .base_addr  (base_addr),
        .len        (len),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .we         (we),
        .write_addr (write_addr),
        .data       (data),
        .busy       (busy),
        .done       (done),
        .err_len    (err_len),
        .wr_count   (wr_count),
        .chksum     (chksum)
    );

    ram_dual_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) ram (
        .write_clk (write_clk),
        .we        (we),
        .write_addr(write_addr),
        .write_data(data),
        .read_clk  (read_clk),
        .read_addr (read_addr),
        .read_data (read_data)
    );

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t               exp_q[$];
    wr_t               act_q[$];
    logic [DATA_W-1:0] exp_mem   [DEPTH];
    bit                mem_valid [DEPTH];
    int                done_cnt = 0;
    int                err_cnt  = 0;
    int                checks   = 0;
    int                errors   = 0;
    logic [ADDR_W:0]   last_count = '0;
    logic [DATA_W-1:0] last_sum   = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Observe write pulses and single-cycle flags mid-cycle.
    always @(negedge write_clk) begin
        if (write_rst_n) begin
            if (we) act_q.push_back('{a: write_addr, d: data});
            if (done) begin
                done_cnt++;
                check("done_with_we", we, 1);
            end
            if (err_len) err_cnt++;
        end
    end

    task automatic next_cycle();
        @(posedge write_clk);
        #1;
    endtask

    task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_q.push_back('{a: a, d: d});
        exp_mem[a]   = d;
        mem_valid[a] = 1'b1;
    endtask

    task automatic compare_writes(input string tag);
        int n;
        check({tag, "_nwrites"}, act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_addr"}, act_q[i].a, exp_q[i].a);
            check({tag, "_data"}, act_q[i].d, exp_q[i].d);
        end
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_we"},       we,         0);
        check({tag, "_waddr"},    write_addr, 0);
        check({tag, "_data"},     data,       0);
        check({tag, "_in_ready"}, in_ready,   0);
        check({tag, "_busy"},     busy,       0);
        check({tag, "_done"},     done,       0);
        check({tag, "_err_len"},  err_len,    0);
        check({tag, "_wr_count"}, wr_count,   0);
        check({tag, "_chksum"},   chksum,     0);
    endtask

    task automatic read_check(input logic [ADDR_W-1:0] a);
        @(negedge read_clk);
        read_addr = a;
        @(posedge read_clk);
        @(posedge read_clk);
        #1;
        check("ram_readback", read_data, exp_mem[a]);
    endtask

    // One frame. abort_at: beats accepted before abort (-1 = none);
    // abort_beat: offer a beat in the abort cycle; alt: valid every other
    // cycle; restart_cyc: cycle index of an ignored second start (-1 = none).
    task automatic run_frame(input string tag, input logic [ADDR_W-1:0] b,
                             input logic [ADDR_W:0] l, input int abort_at,
                             input bit abort_beat, input int gap_pct, input bit alt,
                             input int restart_cyc, input bit fixed,
                             input logic [DATA_W-1:0] seed, input logic [DATA_W-1:0] step);
        int                acc = 0;
        int                cyc = 0;
        int                d0  = done_cnt;
        bit                aborted = 1'b0;
        logic [DATA_W-1:0] sum = '0;
        logic [DATA_W-1:0] nd  = seed;

        start = 1'b1; base_addr = b; len = l;
        next_cycle();
        start = 1'b0;
        while (acc < int'(l)) begin
            if (abort_at >= 0 && acc == abort_at) begin
                aborted = 1'b1;
                break;
            end
            start = (cyc == restart_cyc);
            if (start) begin
                base_addr = 6'h10;
                len       = 7'd2;
            end
            in_valid = alt ? (cyc % 2 == 0) : (int'($urandom_range(0, 99)) >= gap_pct);
            in_data  = fixed ? nd : DATA_W'($urandom);
            check({tag, "_in_ready"}, in_ready, 1);
            check({tag, "_busy"},     busy,     1);
            if (in_valid) begin
                expect_write(b + ADDR_W'(acc), in_data);
                sum = sum + in_data;
                nd  = nd + step;
                acc++;
            end
            next_cycle();
            cyc++;
            if (cyc > 4000) begin
                check({tag, "_timeout"}, 1, 0);
                break;
            end
        end
        start = 1'b0;
        in_valid = 1'b0;

        if (aborted) begin
            abort    = 1'b1;
            in_valid = abort_beat;
            in_data  = DATA_W'($urandom);
            check({tag, "_ready_abort_cyc"}, in_ready, 1);
            if (abort_beat) begin
                expect_write(b + ADDR_W'(acc), in_data);
                sum = sum + in_data;
                acc++;
            end
            next_cycle();
            abort    = 1'b0;
            in_valid = 1'b0;
            check({tag, "_ready_after_abort"}, in_ready, 0);
            check({tag, "_busy_after_abort"},  busy,     0);
            check({tag, "_no_done"},           done,     0);
            next_cycle();
        end else begin
            check({tag, "_done"},      done,     1);
            check({tag, "_final_we"},  we,       1);
            check({tag, "_ready_dn"},  in_ready, 0);
            check({tag, "_busy_dn"},   busy,     1);
            next_cycle();
            check({tag, "_busy_idle"}, busy,     0);
            check({tag, "_done_once"}, done,     0);
        end
        last_count = ADDR_W'(0) + (ADDR_W + 1)'(acc);
        last_sum   = CHK_EN ? sum : '0;
        check({tag, "_wr_count"}, wr_count, last_count);
        check({tag, "_chksum"},   chksum,   last_sum);
        check({tag, "_ndone"},    done_cnt - d0, aborted ? 0 : 1);
        compare_writes(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        int e0;

        // Reset state.
        #3;
        check_zero("reset");
        @(posedge write_clk);
        #1;
        write_rst_n = 1'b1;
        next_cycle();
        check_zero("post_reset");

        // Single-beat frame at address 0.
        run_frame("single", 6'h00, 7'd1, -1, 0, 0, 0, -1, 1, 8'hAA, 8'h00);
        read_check(6'h00);

        // Wrapping frame 3E,3F,00,01.
        run_frame("wrap", 6'h3E, 7'd4, -1, 0, 0, 0, -1, 1, 8'h11, 8'h11);

        // Illegal lengths 0 and DEPTH+1.
        e0 = err_cnt;
        d0 = done_cnt;
        for (int k = 0; k < 2; k++) begin
            start = 1'b1;
            base_addr = 6'h05;
            len = (k == 0) ? 7'd0 : 7'(DEPTH + 1);
            next_cycle();
            start = 1'b0;
            check("badlen_err", err_len, 1);
            check("badlen_busy", busy, 0);
            next_cycle();
            check("badlen_err_pulse", err_len, 0);
            check("badlen_ready", in_ready, 0);
        end
        check("badlen_npulses", err_cnt - e0, 2);
        check("badlen_no_we", act_q.size(), 0);
        check("badlen_wr_count", wr_count, last_count);
        check("badlen_chksum", chksum, last_sum);
        check("badlen_no_done", done_cnt - d0, 0);
        act_q.delete();

        // Abort after three beats.
        run_frame("abort", 6'h30, 7'd8, 3, 0, 0, 0, -1, 0, '0, '0);

        // Alternating valid with an ignored second start.
        run_frame("restart", 6'h08, 7'd4, -1, 0, 0, 1, 2, 0, '0, '0);

        // Reset in the middle of a frame.
        d0 = done_cnt;
        start = 1'b1; base_addr = 6'h20; len = 7'd8;
        next_cycle();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'($urandom);
            expect_write(6'h20 + ADDR_W'(i), in_data);
            next_cycle();
        end
        in_valid = 1'b0;
        #5;
        write_rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        @(posedge write_clk);
        #1;
        write_rst_n = 1'b1;
        last_count = '0;
        last_sum   = '0;
        compare_writes("rst_frame");
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'($urandom);
            check("rst_no_ready", in_ready, 0);
            next_cycle();
        end
        in_valid = 1'b0;
        next_cycle();
        check("rst_no_beat", act_q.size(), 0);
        check("rst_no_done", done_cnt - d0, 0);
        act_q.delete();
        run_frame("after_rst", 6'h3C, 7'd6, -1, 0, 30, 0, -1, 0, '0, '0);

        // Randomized frames, including a full-depth frame and random aborts.
        for (int f = 0; f < 20; f++) begin
            logic [ADDR_W:0] l;
            int              ab;
            l  = (f == 0) ? 7'(DEPTH) : 7'($urandom_range(1, 24));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(l) - 1)) : -1;
            run_frame("rand", ADDR_W'($urandom), l, ab, 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 60)), 0, -1, 0, '0, '0);
            repeat ($urandom_range(0, 3)) next_cycle();
        end

        // RAM readback of previously written locations.
        for (int i = 0; i < 8; i++) begin
            logic [ADDR_W-1:0] a;
            a = ADDR_W'($urandom);
            while (!mem_valid[a]) a = a + 1'b1;
            read_check(a);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
